// File: rtl/mips_pkg.sv
// Shared definitions for the 16-bit pipelined processor: opcodes, FSM states,
// the data-memory command payload and the opcode classification helpers.
package mips_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned OP_W   = 6;
    localparam int unsigned FLAG_W = 2;
    localparam int unsigned CNT_W  = 8;

    // Opcode map; ALU class occupies 000000-001111.
    localparam logic [OP_W-1:0] OP_ALU_FIRST = 6'b000000;
    localparam logic [OP_W-1:0] OP_ALU_LAST  = 6'b001111;
    localparam logic [OP_W-1:0] OP_NWB_10    = 6'b010000;
    localparam logic [OP_W-1:0] OP_NWB_11    = 6'b010001;
    localparam logic [OP_W-1:0] OP_LOAD      = 6'b010100;
    localparam logic [OP_W-1:0] OP_STORE     = 6'b010101;
    localparam logic [OP_W-1:0] OP_WB_16     = 6'b010110;
    localparam logic [OP_W-1:0] OP_NWB_17    = 6'b010111;
    localparam logic [OP_W-1:0] OP_WB_19     = 6'b011001;
    localparam logic [OP_W-1:0] OP_WB_1A     = 6'b011010;
    localparam logic [OP_W-1:0] OP_WB_1B     = 6'b011011;
    localparam logic [OP_W-1:0] OP_NWB_1C    = 6'b011100;
    localparam logic [OP_W-1:0] OP_NWB_1D    = 6'b011101;
    localparam logic [OP_W-1:0] OP_NWB_1E    = 6'b011110;
    localparam logic [OP_W-1:0] OP_NWB_1F    = 6'b011111;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } dm_cmd_t;

    function automatic logic is_mem(input logic [OP_W-1:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    function automatic logic is_wb(input logic [OP_W-1:0] op);
        logic wb;
        wb = 1'b0;
        if (op <= OP_ALU_LAST) begin
            wb = 1'b1;
        end else begin
            case (op)
                OP_WB_16, OP_WB_19, OP_WB_1A, OP_WB_1B: wb = 1'b1;
                default:                               wb = 1'b0;
            endcase
        end
        return wb;
    endfunction

endpackage

// File: rtl/mem_block.sv
// Memory-access pipeline stage: runs loads/stores over a req/ack data-memory
// handshake with a timeout, and passes all other results to writeback.
module mem_block
    import mips_pkg::*;
#(
    parameter int unsigned REG_AW  = 3,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       ans_ex,
    input  logic [15:0]       DM_data,
    input  logic [1:0]        flag_ex,
    input  logic [5:0]        op_ex,
    input  logic [REG_AW-1:0] rd_ex,
    input  logic [15:0]       dm_rdata,
    input  logic              dm_ack,
    output logic              dm_req,
    output logic              dm_we,
    output logic [15:0]       dm_addr,
    output logic [15:0]       dm_wdata,
    output logic [15:0]       ans_mem,
    output logic [1:0]        flag_mem,
    output logic [REG_AW-1:0] rd_mem,
    output logic              wb_en,
    output logic              stall,
    output logic              mem_err
);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    dm_cmd_t             cmd_q, cmd_d;
    logic                req_q, req_d;
    logic [DATA_W-1:0]   ans_q, ans_d;
    logic [FLAG_W-1:0]   flag_q, flag_d;
    logic [REG_AW-1:0]   rd_q, rd_d;
    logic                wb_q, wb_d;
    logic                err_q, err_d;

    // Next-state, next-output and combinational stall.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        req_d   = req_q;
        ans_d   = ans_q;
        flag_d  = flag_q;
        rd_d    = rd_q;
        wb_d    = 1'b0;
        err_d   = err_q;
        stall   = 1'b0;

        case (state_q)
            IDLE: begin
                if (is_mem(op_ex)) begin
                    cmd_d.we    = (op_ex == OP_STORE);
                    cmd_d.addr  = ans_ex;
                    cmd_d.wdata = DM_data;
                    rd_d        = rd_ex;
                    req_d       = 1'b1;
                    cnt_d       = '0;
                    state_d     = REQ;
                    stall       = 1'b1;
                end else begin
                    ans_d  = ans_ex;
                    flag_d = flag_ex;
                    rd_d   = rd_ex;
                    wb_d   = is_wb(op_ex);
                end
            end
            REQ: begin
                if (dm_ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                    if (!cmd_q.we) begin
                        ans_d  = dm_rdata;
                        flag_d = {dm_rdata == 16'h0000, 1'b0};
                        wb_d   = 1'b1;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Abandon the access; the aborted load never writes back.
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    ans_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cmd_q   <= '0;
            req_q   <= 1'b0;
            ans_q   <= '0;
            flag_q  <= '0;
            rd_q    <= '0;
            wb_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            req_q   <= req_d;
            ans_q   <= ans_d;
            flag_q  <= flag_d;
            rd_q    <= rd_d;
            wb_q    <= wb_d;
            err_q   <= err_d;
        end
    end

    assign dm_req   = req_q;
    assign dm_we    = cmd_q.we;
    assign dm_addr  = cmd_q.addr;
    assign dm_wdata = cmd_q.wdata;
    assign ans_mem  = ans_q;
    assign flag_mem = flag_q;
    assign rd_mem   = rd_q;
    assign wb_en    = wb_q;
    assign mem_err  = err_q;

endmodule

// File: tb/tb_mem_block.sv
// Bench for mem_block: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_block;

    localparam int unsigned TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] ans_ex, DM_data, dm_rdata;
    logic [1:0]  flag_ex;
    logic [5:0]  op_ex;
    logic [2:0]  rd_ex;
    logic        dm_ack;
    logic        dm_req, dm_we, wb_en, stall, mem_err;
    logic [15:0] dm_addr, dm_wdata, ans_mem;
    logic [1:0]  flag_mem;
    logic [2:0]  rd_mem;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;
    bit last_stall;
    logic step_stall;

    mem_block #(.REG_AW(3), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .ans_ex(ans_ex), .DM_data(DM_data),
        .flag_ex(flag_ex), .op_ex(op_ex), .rd_ex(rd_ex), .dm_rdata(dm_rdata),
        .dm_ack(dm_ack), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .ans_mem(ans_mem), .flag_mem(flag_mem),
        .rd_mem(rd_mem), .wb_en(wb_en), .stall(stall), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: one outstanding access record plus the visible stage outputs.
    bit          m_busy = 0;
    int          m_waited = 0;
    logic        m_req = 0, m_we = 0, m_wb = 0, m_err = 0;
    logic [15:0] m_addr = 0, m_wdata = 0, m_ans = 0;
    logic [1:0]  m_flag = 0;
    logic [2:0]  m_rd = 0;

    function automatic bit ref_mem(input logic [5:0] op);
        return op == 6'd20 || op == 6'd21;
    endfunction

    function automatic bit ref_wb(input logic [5:0] op);
        return op inside {[6'd0:6'd15], 6'd22, [6'd25:6'd27]};
    endfunction

    function automatic bit ref_stall();
        if (!m_busy) return ref_mem(op_ex);
        return !dm_ack && (m_waited + 1 != TIMEOUT);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 0; m_waited = 0; m_req = 0; m_we = 0; m_wb = 0; m_err = 0;
            m_addr = 0; m_wdata = 0; m_ans = 0; m_flag = 0; m_rd = 0;
        end else if (!m_busy) begin
            m_wb = 0;
            if (ref_mem(op_ex)) begin
                m_busy = 1; m_waited = 0; m_req = 1;
                m_we = (op_ex == 6'd21); m_addr = ans_ex; m_wdata = DM_data; m_rd = rd_ex;
            end else begin
                m_ans = ans_ex; m_flag = flag_ex; m_rd = rd_ex; m_wb = ref_wb(op_ex);
            end
        end else begin
            m_wb = 0;
            if (dm_ack) begin
                m_busy = 0; m_req = 0;
                if (!m_we) begin
                    m_ans = dm_rdata; m_flag = (dm_rdata == 0) ? 2'b10 : 2'b00; m_wb = 1;
                end
            end else if (m_waited + 1 == TIMEOUT) begin
                m_busy = 0; m_req = 0; m_err = 1; m_ans = 0;
            end else begin
                m_waited++;
            end
        end
    end

    // Compare process, mid-cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            last_stall = ref_stall();
            check("stall",    32'(stall),    32'(last_stall));
            check("dm_req",   32'(dm_req),   32'(m_req));
            check("dm_we",    32'(dm_we),    32'(m_we));
            check("dm_addr",  32'(dm_addr),  32'(m_addr));
            check("dm_wdata", 32'(dm_wdata), 32'(m_wdata));
            check("ans_mem",  32'(ans_mem),  32'(m_ans));
            check("flag_mem", 32'(flag_mem), 32'(m_flag));
            check("rd_mem",   32'(rd_mem),   32'(m_rd));
            check("wb_en",    32'(wb_en),    32'(m_wb));
            check("mem_err",  32'(mem_err),  32'(m_err));
        end
    end

    task automatic drive(input logic [5:0] op, input logic [15:0] a, input logic [15:0] d,
                         input logic [1:0] f, input logic [2:0] r, input logic ack,
                         input logic [15:0] rdat, input logic rst);
        op_ex = op; ans_ex = a; DM_data = d; flag_ex = f; rd_ex = r;
        dm_ack = ack; dm_rdata = rdat; reset = rst;
    endtask

    // Drive one cycle, sample combinational stall, then step past the edge.
    task automatic step(input logic [5:0] op, input logic [15:0] a, input logic [15:0] d,
                        input logic [1:0] f, input logic [2:0] r, input logic ack,
                        input logic [15:0] rdat, input logic rst);
        drive(op, a, d, f, r, ack, rdat, rst);
        #1 step_stall = stall;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int stalls;
        int wbs;
        logic [15:0] wb_vals[$];
        drive(6'd16, 0, 0, 0, 0, 0, 0, 1);
        @(posedge clk); #1;
        cmp_en = 1;
        step(6'd16, 0, 0, 0, 0, 0, 0, 1);
        check("reset_ans", 32'(ans_mem), 0);
        check("reset_req", 32'(dm_req), 0);
        check("reset_wb",  32'(wb_en), 0);
        check("reset_err", 32'(mem_err), 0);

        // Pass-through
        step(6'd0, 16'h1234, 0, 2'b01, 3'd3, 0, 0, 0);
        check("pt_stall", 32'(step_stall), 0);
        check("pt_ans",   32'(ans_mem), 32'h1234);
        check("pt_rd",    32'(rd_mem), 3);
        check("pt_wb",    32'(wb_en), 1);
        check("pt_flag",  32'(flag_mem), 1);

        // Load with two wait states
        stalls = 0; n = 0;
        step(6'd20, 16'h0040, 0, 0, 3'd5, 0, 0, 0); stalls += step_stall; n += dm_req;
        check("ld_addr", 32'(dm_addr), 32'h0040);
        check("ld_we",   32'(dm_we), 0);
        step(6'd20, 16'h0040, 0, 0, 3'd5, 0, 0, 0); stalls += step_stall; n += dm_req;
        step(6'd20, 16'h0040, 0, 0, 3'd5, 0, 0, 0); stalls += step_stall; n += dm_req;
        step(6'd20, 16'h0040, 0, 0, 3'd5, 1, 16'hBEEF, 0); stalls += step_stall; n += dm_req;
        check("ld_stall_cycles", 32'(stalls), 3);
        check("ld_req_cycles",   32'(n), 3);
        check("ld_ans", 32'(ans_mem), 32'hBEEF);
        check("ld_wb",  32'(wb_en), 1);
        check("ld_rd",  32'(rd_mem), 5);
        step(6'd16, 0, 0, 0, 0, 0, 0, 0);
        check("ld_wb_once", 32'(wb_en), 0);

        // Store, zero wait
        step(6'd21, 16'h0010, 16'h00FF, 0, 3'd1, 0, 0, 0);
        check("st_stall0", 32'(step_stall), 1);
        check("st_we",    32'(dm_we), 1);
        check("st_wdata", 32'(dm_wdata), 32'h00FF);
        check("st_req",   32'(dm_req), 1);
        step(6'd21, 16'h0010, 16'h00FF, 0, 3'd1, 1, 16'h5555, 0);
        check("st_stall1", 32'(step_stall), 0);
        check("st_req_drop", 32'(dm_req), 0);
        check("st_wb", 32'(wb_en), 0);

        // Timeout
        step(6'd20, 16'h0080, 0, 0, 3'd2, 0, 0, 0);
        n = 0;
        while (dm_req && n < 40) begin
            n++;
            step(6'd20, 16'h0080, 0, 0, 3'd2, 0, 0, 0);
        end
        check("to_req_cycles", 32'(n), 15);
        check("to_err", 32'(mem_err), 1);
        check("to_wb",  32'(wb_en), 0);
        check("to_ans", 32'(ans_mem), 0);
        step(6'd16, 0, 0, 0, 0, 1, 16'h1111, 0);
        check("to_err_sticky", 32'(mem_err), 1);
        check("to_idle_ack_ignored", 32'(dm_req), 0);

        // Reset in the second REQ cycle, then a late ack
        step(6'd20, 16'h0100, 0, 0, 3'd4, 0, 0, 0);
        step(6'd20, 16'h0100, 0, 0, 3'd4, 0, 0, 0);
        step(6'd20, 16'h0100, 0, 0, 3'd4, 0, 0, 1);
        check("rst_req", 32'(dm_req), 0);
        check("rst_err", 32'(mem_err), 0);
        check("rst_rd",  32'(rd_mem), 0);
        step(6'd16, 0, 0, 0, 0, 1, 16'h2222, 0);
        check("late_ack_wb",  32'(wb_en), 0);
        check("late_ack_req", 32'(dm_req), 0);

        // Back-to-back load, store, add; load returns zero (Z flag)
        wbs = 0;
        wb_vals.delete();
        step(6'd20, 16'h0004, 0, 0, 3'd6, 0, 0, 0);
        if (wb_en) begin wbs++; wb_vals.push_back(ans_mem); end
        step(6'd20, 16'h0004, 0, 0, 3'd6, 1, 16'h0000, 0);
        check("b2b_ld_flag", 32'(flag_mem), 32'b10);
        if (wb_en) begin wbs++; wb_vals.push_back(ans_mem); end
        step(6'd21, 16'h0008, 16'hCAFE, 0, 3'd7, 0, 0, 0);
        check("b2b_st_captured", 32'(dm_req), 1);
        if (wb_en) begin wbs++; wb_vals.push_back(ans_mem); end
        step(6'd21, 16'h0008, 16'hCAFE, 0, 3'd7, 1, 16'h9999, 0);
        if (wb_en) begin wbs++; wb_vals.push_back(ans_mem); end
        step(6'd1, 16'h0077, 0, 0, 3'd1, 0, 0, 0);
        if (wb_en) begin wbs++; wb_vals.push_back(ans_mem); end
        step(6'd16, 0, 0, 0, 0, 0, 0, 0);
        if (wb_en) begin wbs++; wb_vals.push_back(ans_mem); end
        check("b2b_wb_count", 32'(wbs), 2);
        if (wb_vals.size() == 2) begin
            check("b2b_order0", 32'(wb_vals[0]), 32'h0000);
            check("b2b_order1", 32'(wb_vals[1]), 32'h0077);
        end

        // Randomized traffic; upstream holds its outputs while stalled
        for (int i = 0; i < 2500; i++) begin
            logic [5:0] op;
            logic       ack;
            bit         dead;
            dead = (i % 300) >= 250;
            ack  = !dead && ($urandom_range(0, 99) < 35);
            if (!last_stall) begin
                case ($urandom_range(0, 5))
                    0:       op = 6'd20;
                    1:       op = 6'd21;
                    default: op = 6'($urandom);
                endcase
                op_ex = op;
                ans_ex = 16'($urandom);
                DM_data = 16'($urandom);
                flag_ex = 2'($urandom);
                rd_ex = 3'($urandom);
            end
            dm_ack = ack;
            dm_rdata = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            reset = ($urandom_range(0, 299) == 0);
            @(posedge clk); #1;
        end
        reset = 0;
        @(posedge clk); #1;
        cmp_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_block.md
# mem_block

Memory-access stage of the 16-bit pipelined processor. It sits directly downstream of the execution stage and consumes that stage's registered ALU result, store data, flags, opcode and destination register. Loads and stores run against an external data memory through a req/ack handshake, stalling the pipeline while a transfer is outstanding. All other results pass through to writeback with one cycle of latency.

## Interface
Parameters:
- REG_AW, 3: destination-register index width.
- TIMEOUT, 15: maximum REQ cycles without dm_ack before the access is aborted (1..255).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ans_ex  in  16  execution result; this is the address for load/store.
- DM_data  in  16  store data from the execution stage.
- flag_ex  in  2  {Z,V} flags from the execution stage.
- op_ex  in  6  opcode accompanying ans_ex.
- rd_ex  in  REG_AW  destination register.
- dm_rdata  in  16  read data from data memory; valid when dm_ack=1.
- dm_ack  in  1  memory completion strobe (one cycle).
- dm_req  out  1  memory request (registered).
- dm_we  out  1  1 = store, 0 = load (registered).
- dm_addr  out  16  memory address (registered).
- dm_wdata  out  16  store data (registered).
- ans_mem  out  16  writeback value.
- flag_mem  out  2  flags aligned with ans_mem.
- rd_mem  out  REG_AW  writeback destination.
- wb_en  out  1  writeback strobe for ans_mem/rd_mem.
- stall  out  1  combinational; upstream holds its outputs while 1.
- mem_err  out  1  sticky timeout flag.

## Operation
- Opcodes:
  - OP_LOAD=6'b010100, OP_STORE=6'b010101.
  - Writeback class: 000000–001111, 010110, 011001–011011.
  - No writeback: 010000, 010001, 010111, 011100–011111, and all undefined codes.
- FSM states: IDLE, REQ.
- IDLE with non-memory op:
  - Register ans_mem←ans_ex, flag_mem←flag_ex, rd_mem←rd_ex.
  - wb_en←is_wb(op_ex).
  - stall=0.
- IDLE with load/store:
  - Register dm_addr←ans_ex, dm_wdata←DM_data, dm_we←(op==STORE), rd_mem←rd_ex, dm_req←1, wb_en←0.
  - Clear the timeout counter; next state REQ.
  - stall=1.
- REQ:
  - Inputs are ignored; dm_req/dm_we/dm_addr/dm_wdata are held stable; wb_en←0.
  - dm_ack=1:
    - dm_req←0; next state IDLE.
    - Load: ans_mem←dm_rdata, flag_mem←{dm_rdata==0,0}, wb_en←1.
    - Store: wb_en←0.
    - stall=0 this cycle, so upstream advances on the same edge.
  - dm_ack=0: counter++, stall=1.
  - Counter reaching TIMEOUT−1 with dm_ack=0: dm_req←0, mem_err←1, ans_mem←0, wb_en←0, next state IDLE; stall=0 that cycle.
- stall = (IDLE & is_mem(op_ex)) | (REQ & ~dm_ack & ~timeout_hit).
- dm_ack while IDLE is ignored.
- mem_err is cleared only by reset.

## Timing
- Reset: state IDLE; all outputs and internal registers 0, including dm_req, wb_en, ans_mem, flag_mem, rd_mem and mem_err.
- Reset mid-REQ drops dm_req at that edge. A late dm_ack arriving afterwards is ignored.
- Pass-through latency: 1 cycle, input to ans_mem/wb_en.
- Load with zero-wait memory (ack in first REQ cycle):
  - Capture edge, then ack edge; wb_en high 2 cycles after the op is presented.
  - stall is high for exactly 1 cycle.
- Every wait cycle adds one cycle of stall and latency.
- wb_en is a single-cycle pulse per retiring instruction; an instruction never writes back twice.
- Back-to-back memory ops: the second is captured in the IDLE cycle immediately after the first completes.

## Structure
- Shared package mips_pkg holds:
  - OP_LOAD/OP_STORE localparams and the full opcode list.
  - The state enum {IDLE, REQ}.
  - Functions is_mem(op) and is_wb(op), which the decode stage reuses.
- Single module, no sub-module. The timeout counter is an 8-bit register.

## Test plan
- Pass-through: op 000000, ans_ex=16'h1234, rd_ex=3 → next cycle ans_mem=16'h1234, rd_mem=3, wb_en=1, stall never high.
- Load, 2 wait states: op 010100, ans_ex=16'h0040, dm_rdata=16'hBEEF with ack on the 3rd REQ cycle → dm_req high 3 cycles, dm_we=0, dm_addr=16'h0040; stall high 3 cycles; ans_mem=16'hBEEF, wb_en pulses once.
- Store, zero wait: op 010101, ans_ex=16'h0010, DM_data=16'h00FF → dm_we=1, dm_wdata=16'h00FF, dm_req for 1 cycle, wb_en stays 0, stall 1 cycle.
- Timeout: load with dm_ack held 0, TIMEOUT=15 → dm_req drops after 15 REQ cycles, mem_err=1 and stays 1, wb_en=0, FSM returns to IDLE.
- Reset mid-REQ: assert reset on the 2nd REQ cycle, then pulse dm_ack → all outputs 0, no wb_en pulse, mem_err=0.
- Back-to-back: load, store, add in consecutive slots with zero-wait memory → exactly one wb_en for the load and one for the add, in program order.
